// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the mux_arbiter_rr round-robin arbiter.
package mux_arb_pkg;

    localparam int unsigned DATA_W_DEF = 2;
    localparam int unsigned STATS_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mux_arb_fsm.sv
// Grant sequencer for mux_arbiter_rr: owns the grant state, the burst counter
// and the round-robin tie-break memory.
module mux_arb_fsm
    import mux_arb_pkg::*;
#(
    parameter int unsigned BURST_MAX = 4
) (
    input  logic clk,
    input  logic reset_L,
    input  logic valid_in0,
    input  logic valid_in1,
    input  logic out_free,
    output logic selector,
    output logic grant0,
    output logic grant1
);

    localparam int unsigned      CNT_W   = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_served_q, last_served_d;
    logic             cur_id, cur_valid, oth_valid;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q       <= IDLE;
            burst_cnt_q   <= '0;
            last_served_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            burst_cnt_q   <= burst_cnt_d;
            last_served_q <= last_served_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        burst_cnt_d   = burst_cnt_q;
        last_served_d = last_served_q;
        cur_id        = (state_q == G1);
        cur_valid     = cur_id ? valid_in1 : valid_in0;
        oth_valid     = cur_id ? valid_in0 : valid_in1;
        // With nobody waiting the count wraps back to 1 instead of saturating.
        cnt_inc       = (burst_cnt_q < CNT_MAX) ? burst_cnt_q + CNT_ONE : CNT_ONE;

        unique case (state_q)
            IDLE: begin
                if (valid_in0 && valid_in1) begin
                    state_d = last_served_q ? G0 : G1;
                end else if (valid_in0) begin
                    state_d = G0;
                end else if (valid_in1) begin
                    state_d = G1;
                end
            end
            G0, G1: begin
                if (!cur_valid) begin
                    state_d       = oth_valid ? (cur_id ? G0 : G1) : IDLE;
                    burst_cnt_d   = '0;
                    last_served_d = cur_id;
                end else if (out_free) begin
                    if (oth_valid && (cnt_inc == CNT_MAX)) begin
                        state_d       = cur_id ? G0 : G1;
                        burst_cnt_d   = '0;
                        last_served_d = cur_id;
                    end else begin
                        burst_cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign selector = (state_q == G1);
    assign grant0   = (state_q == G0);
    assign grant1   = (state_q == G1);

endmodule

// File: rtl/mux_arbiter_rr.sv
// Round-robin 2:1 mux arbiter with a single registered output stage.
// Optional per-requester transfer counters via `define MUX_ARB_STATS_EN.
module mux_arbiter_rr
    import mux_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              valid_in0,
    input  logic [DATA_W-1:0] data_in0,
    output logic              ready_out0,
    input  logic              valid_in1,
    input  logic [DATA_W-1:0] data_in1,
    output logic              ready_out1,
    output logic              selector,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ready_in
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0] grant_cnt0,
    output logic [STATS_W-1:0] grant_cnt1
`endif
);

    logic              valid_out_q, valid_out_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              out_free, grant0, grant1, xfer0, xfer1;

    mux_arb_fsm #(
        .BURST_MAX(BURST_MAX)
    ) u_fsm (
        .clk      (clk),
        .reset_L  (reset_L),
        .valid_in0(valid_in0),
        .valid_in1(valid_in1),
        .out_free (out_free),
        .selector (selector),
        .grant0   (grant0),
        .grant1   (grant1)
    );

    assign out_free   = !valid_out_q || ready_in;
    assign ready_out0 = grant0 && out_free;
    assign ready_out1 = grant1 && out_free;
    assign xfer0      = valid_in0 && ready_out0;
    assign xfer1      = valid_in1 && ready_out1;

    // A load in the same cycle as a downstream pop keeps valid_out high.
    always_comb begin
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
        if (xfer0 || xfer1) begin
            valid_out_d = 1'b1;
            data_out_d  = xfer1 ? data_in1 : data_in0;
        end else if (ready_in) begin
            valid_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;

`ifdef MUX_ARB_STATS_EN
    localparam logic [STATS_W-1:0] STAT_ONE = STATS_W'(1);

    logic [STATS_W-1:0] grant_cnt0_q, grant_cnt1_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            if (xfer0 && (grant_cnt0_q != '1)) grant_cnt0_q <= grant_cnt0_q + STAT_ONE;
            if (xfer1 && (grant_cnt1_q != '1)) grant_cnt1_q <= grant_cnt1_q + STAT_ONE;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_mux_arbiter_rr.sv
// Self-checking bench for mux_arbiter_rr: directed table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_mux_arbiter_rr;

    localparam int BMAX = 4;
    localparam int DW   = 2;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          valid_in0 = 1'b0, valid_in1 = 1'b0, ready_in = 1'b0;
    logic [DW-1:0] data_in0 = '0, data_in1 = '0;
    logic          ready_out0, ready_out1, selector, valid_out;
    logic [DW-1:0] data_out;
`ifdef MUX_ARB_STATS_EN
    logic [7:0]    grant_cnt0, grant_cnt1;
`endif

    int checks = 0;
    int failures = 0;

    mux_arbiter_rr #(
        .DATA_W(DW),
        .BURST_MAX(BMAX)
    ) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .valid_in0 (valid_in0),
        .data_in0  (data_in0),
        .ready_out0(ready_out0),
        .valid_in1 (valid_in1),
        .data_in1  (data_in1),
        .ready_out1(ready_out1),
        .selector  (selector),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ready_in  (ready_in)
`ifdef MUX_ARB_STATS_EN
        ,
        .grant_cnt0(grant_cnt0),
        .grant_cnt1(grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the channel, how long they have held it,
    // who was served last, and what sits in the output register.
    int            m_owner, m_streak, m_last;
    int            m_gcnt[2];
    bit            m_vout;
    logic [DW-1:0] m_dout;

    task automatic model_reset();
        m_owner = -1; m_streak = 0; m_last = 1;
        m_gcnt[0] = 0; m_gcnt[1] = 0;
        m_vout = 1'b0; m_dout = '0;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        valid_in0 = 1'b0; valid_in1 = 1'b0; ready_in = 1'b0;
        data_in0 = '0; data_in1 = '0;
        repeat (2) @(posedge clk);
        #1 reset_L = 1'b1;
        model_reset();
    endtask

    task automatic step_model(input bit v0, input bit v1, input logic [DW-1:0] d0,
                              input logic [DW-1:0] d1, input bit rdy);
        bit            v[2];
        logic [DW-1:0] d[2];
        bit            free;
        int            took, o;
        v[0] = v0; v[1] = v1; d[0] = d0; d[1] = d1;
        valid_in0 = v0; valid_in1 = v1; data_in0 = d0; data_in1 = d1; ready_in = rdy;
        #1;
        free = !m_vout || rdy;
        chk("rnd_selector", selector, m_owner == 1);
        chk("rnd_ready_out0", ready_out0, (m_owner == 0) && free);
        chk("rnd_ready_out1", ready_out1, (m_owner == 1) && free);
        chk("rnd_valid_out", valid_out, m_vout);
        chk("rnd_data_out", data_out, m_dout);
`ifdef MUX_ARB_STATS_EN
        chk("rnd_grant_cnt0", grant_cnt0, m_gcnt[0]);
        chk("rnd_grant_cnt1", grant_cnt1, m_gcnt[1]);
`endif
        took = -1;
        if (m_owner >= 0 && v[m_owner] && free) took = m_owner;
        if (took >= 0) begin
            m_dout = d[took];
            m_vout = 1'b1;
            if (m_gcnt[took] < 255) m_gcnt[took]++;
        end else if (rdy) begin
            m_vout = 1'b0;
        end
        if (m_owner < 0) begin
            if (v[0] && v[1]) m_owner = 1 - m_last;
            else if (v[0])    m_owner = 0;
            else if (v[1])    m_owner = 1;
        end else begin
            o = m_owner;
            if (!v[o]) begin
                m_last = o; m_streak = 0;
                m_owner = v[1-o] ? 1 - o : -1;
            end else if (took >= 0) begin
                m_streak = (m_streak < BMAX) ? m_streak + 1 : 1;
                if (v[1-o] && m_streak == BMAX) begin
                    m_owner = 1 - o; m_streak = 0; m_last = o;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit v0; bit v1; logic [DW-1:0] d0; logic [DW-1:0] d1; bit rdy;
        bit sel; bit vout; logic [DW-1:0] dout; bit r0; bit r1;
    } vec_t;

    vec_t tbl[14];

    initial begin
        //          v0 v1 d0 d1 rdy | sel vout dout r0 r1
        tbl[0]  = '{1, 0, 3, 0, 1,   0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 3, 0, 1,   0, 0, 0, 1, 0};
        tbl[2]  = '{1, 0, 1, 0, 1,   0, 1, 3, 1, 0};
        tbl[3]  = '{0, 0, 0, 0, 1,   0, 1, 1, 1, 0};
        tbl[4]  = '{0, 0, 0, 0, 1,   0, 0, 1, 0, 0};
        tbl[5]  = '{1, 1, 0, 2, 1,   0, 0, 1, 0, 0};
        tbl[6]  = '{1, 1, 0, 2, 1,   1, 0, 1, 0, 1};
        tbl[7]  = '{1, 1, 0, 2, 0,   1, 1, 2, 0, 0};
        tbl[8]  = '{1, 1, 0, 2, 0,   1, 1, 2, 0, 0};
        tbl[9]  = '{1, 1, 0, 1, 1,   1, 1, 2, 0, 1};
        tbl[10] = '{1, 0, 3, 0, 1,   1, 1, 1, 0, 1};
        tbl[11] = '{1, 0, 3, 0, 1,   0, 0, 1, 1, 0};
        tbl[12] = '{0, 0, 0, 0, 1,   0, 1, 3, 1, 0};
        tbl[13] = '{0, 0, 0, 0, 0,   0, 0, 3, 0, 0};

        do_reset();
        chk("reset_valid_out", valid_out, 0);
        chk("reset_data_out", data_out, 0);
        chk("reset_selector", selector, 0);

        for (int i = 0; i < 14; i++) begin
            valid_in0 = tbl[i].v0; valid_in1 = tbl[i].v1;
            data_in0 = tbl[i].d0; data_in1 = tbl[i].d1; ready_in = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d_selector", i), selector, tbl[i].sel);
            chk($sformatf("tbl%0d_valid_out", i), valid_out, tbl[i].vout);
            chk($sformatf("tbl%0d_data_out", i), data_out, tbl[i].dout);
            chk($sformatf("tbl%0d_ready_out0", i), ready_out0, tbl[i].r0);
            chk($sformatf("tbl%0d_ready_out1", i), ready_out1, tbl[i].r1);
            @(posedge clk);
            #1;
        end

        // Both requesting from reset: G0 first, then alternating bursts of BMAX.
        do_reset();
        valid_in0 = 1; valid_in1 = 1; data_in0 = 2'd1; data_in1 = 2'd2; ready_in = 1;
        for (int c = 0; c < 17; c++) begin
            int k;
            #1;
            k = c - 1;
            if (c == 0) begin
                chk("both_idle_selector", selector, 0);
                chk("both_idle_ready0", ready_out0, 0);
            end else begin
                chk("both_selector", selector, (k / BMAX) % 2);
                chk("both_ready", selector ? ready_out1 : ready_out0, 1);
                if (k >= 1) begin
                    chk("both_valid_out", valid_out, 1);
                    chk("both_data_out", data_out, (((k - 1) / BMAX) % 2) ? 2 : 1);
                end
            end
            @(posedge clk);
            #1;
        end

        // Backpressure in G1 freezes the burst count.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            valid_in1 = 1; data_in1 = 2'd1; data_in0 = 2'd3;
            valid_in0 = (c >= 2);
            ready_in = !(c >= 3 && c <= 5);
            #1;
            if (c >= 3 && c <= 5) begin
                chk("bp_ready_out1", ready_out1, 0);
                chk("bp_data_out", data_out, 1);
                chk("bp_valid_out", valid_out, 1);
                chk("bp_selector", selector, 1);
            end
            if (c == 6 || c == 7) begin
                chk("bp_resume_selector", selector, 1);
                chk("bp_resume_ready1", ready_out1, 1);
            end
            if (c == 8) begin
                chk("bp_switch_selector", selector, 0);
                chk("bp_switch_ready0", ready_out0, 1);
            end
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-burst.
        do_reset();
        for (int c = 0; c < 4; c++) step_model(1, 1, 2'd3, 2'd2, 1);
        #2 reset_L = 1'b0;
        #1;
        chk("areset_valid_out", valid_out, 0);
        chk("areset_data_out", data_out, 0);
        chk("areset_selector", selector, 0);
        chk("areset_ready_out0", ready_out0, 0);
        chk("areset_ready_out1", ready_out1, 0);
`ifdef MUX_ARB_STATS_EN
        chk("areset_grant_cnt0", grant_cnt0, 0);
        chk("areset_grant_cnt1", grant_cnt1, 0);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 2500; n++) begin
            step_model($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                       DW'($urandom), DW'($urandom),
                       (n < 1200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0));
        end

`ifdef MUX_ARB_STATS_EN
        do_reset();
        for (int n = 0; n < 305; n++) step_model(1, 0, DW'($urandom), 2'd0, 1);
        chk("stats_sat_cnt0", grant_cnt0, 255);
        chk("stats_sat_cnt1", grant_cnt1, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
